// File: rtl/demux16_collector_pkg.sv
// Shared constants, FSM encoding and the stream-index to frame-bit mapping
// used by both the 16:1 mux and this demux/collector.
package demux16_collector_pkg;

  localparam int FRAME_W = 16;
  localparam int SEL_W   = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Stream index s lives in frame bit 15-s (sel=0 addresses the MSB).
  function automatic logic [SEL_W-1:0] msb_index(input logic [SEL_W-1:0] s);
    return SEL_W'(FRAME_W - 1) - s;
  endfunction

endpackage

// File: rtl/demux16_collector_if.sv
// Bit-stream input and frame output of the collector, bundled for port use.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The producer keeps in_bit/sel/in_last stable while in_valid is high and
// in_ready is low; the frame on out is stable while out_valid is high.
interface demux16_collector_if
  import demux16_collector_pkg::*;
();

  logic               in_valid;
  logic               in_ready;
  logic               in_bit;
  logic               addr_mode;
  logic [SEL_W-1:0]   sel;
  logic               in_last;
  logic               abort;
  logic [FRAME_W-1:0] out;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   bit_index;
  state_t             state;

  modport master (
    output in_valid, in_bit, addr_mode, sel, in_last, abort, out_ready,
    input  in_ready, out, out_valid, bit_index, state
  );

  modport slave (
    input  in_valid, in_bit, addr_mode, sel, in_last, abort, out_ready,
    output in_ready, out, out_valid, bit_index, state
  );

endinterface

// File: rtl/demux16_bitreg.sv
// 16-bit frame register with a 1-to-16 index decoder, single-bit write
// and a global clear that wins over the write.
module demux16_bitreg
  import demux16_collector_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               we,
  input  logic [SEL_W-1:0]   index,
  input  logic               wr_bit,
  output logic [FRAME_W-1:0] bits
);

  logic [FRAME_W-1:0] onehot;

  assign onehot = FRAME_W'(1) << msb_index(index);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bits <= '0;
    end else if (we) begin
      bits <= wr_bit ? (bits | onehot) : (bits & ~onehot);
    end
  end

endmodule

// File: rtl/demux16_collector.sv
// Serial-to-frame collector: steers accepted bits into a 16-bit frame and
// hands the completed frame out under a valid/ready handshake.
module demux16_collector
  import demux16_collector_pkg::*;
#(
  parameter bit CLEAR_ON_RELEASE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  demux16_collector_if.slave bus
);

  state_t             state;
  logic [SEL_W-1:0]   bit_index;
  logic               out_valid;
  logic [FRAME_W-1:0] frame;

  logic               accept;
  logic               release_frame;
  logic               clear;
  logic               write_en;
  logic [SEL_W-1:0]   write_index;

  // in_ready depends on state alone, so no input reaches it combinationally.
  assign bus.in_ready  = (state == COLLECT);
  assign bus.out       = frame;
  assign bus.out_valid = out_valid;
  assign bus.bit_index = bit_index;
  assign bus.state     = state;

  assign accept        = bus.in_valid && (state == COLLECT);
  assign release_frame = (state == HOLD) && bus.out_ready;
  assign clear         = bus.abort || (release_frame && CLEAR_ON_RELEASE);
  assign write_en      = accept && !bus.abort;
  assign write_index   = bus.addr_mode ? bus.sel : bit_index;

  demux16_bitreg u_bitreg (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .we     (write_en),
    .index  (write_index),
    .wr_bit (bus.in_bit),
    .bits   (frame)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      state     <= COLLECT;
      bit_index <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (!bus.addr_mode) begin
              bit_index <= bit_index + 1'b1;
              if (bit_index == SEL_W'(FRAME_W - 1)) begin
                state     <= HOLD;
                out_valid <= 1'b1;
              end
            end else if (bus.in_last) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state     <= COLLECT;
            out_valid <= 1'b0;
            bit_index <= '0;
          end
        end
        default: begin
          state     <= COLLECT;
          out_valid <= 1'b0;
          bit_index <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux16_collector.sv
// Self-checking bench for demux16_collector against a stream-index model.
module tb_demux16_collector;
  import demux16_collector_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux16_collector_if ifc ();

  demux16_collector #(.CLEAR_ON_RELEASE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model (indexed by stream position) ----------------
  bit   m_frame[16];
  int   m_count;
  bit   m_held;
  logic [15:0] exp_q[$];
  logic [0:0]  bit_q[$];

  function automatic logic [15:0] model_out();
    logic [15:0] v;
    for (int s = 0; s < 16; s++) v[15 - s] = m_frame[s];
    return v;
  endfunction

  function automatic logic [21:0] model_vec();
    return {model_out(), m_held, ~m_held, 4'(m_count)};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {ifc.out, ifc.out_valid, ifc.in_ready, ifc.bit_index};
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 16; s++) m_frame[s] = 1'b0;
    m_count = 0;
    m_held  = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    if (rst || ifc.abort) begin
      model_clear();
    end else if (!m_held) begin
      if (ifc.in_valid) begin
        if (!ifc.addr_mode) begin
          m_frame[m_count] = ifc.in_bit;
          if (m_count == 15) begin
            m_held  = 1'b1;
            m_count = 0;
          end else begin
            m_count++;
          end
        end else begin
          m_frame[ifc.sel] = ifc.in_bit;
          if (ifc.in_last) m_held = 1'b1;
        end
      end
    end else if (ifc.out_ready) begin
      for (int s = 0; s < 16; s++) m_frame[s] = 1'b0;
      m_held  = 1'b0;
      m_count = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (dut_vec() !== {16'h0000, 1'b0, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", dut_vec(), {16'h0000, 1'b0, 1'b1, 4'd0});
    end
    n_checks++;
    if (ifc.state !== COLLECT) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", ifc.state, COLLECT);
    end
  endtask

  task automatic test_auto_frame();
    logic [15:0] stream;
    stream = 16'hAD92;
    ifc.addr_mode = 1'b0;
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    for (int s = 0; s < 16; s++) begin
      ifc.in_bit = stream[15 - s];
      bit_q.push_back(stream[15 - s]);
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL auto_step%0d: got %h expected %h", s, dut_vec(), model_vec());
      end
    end
    ifc.in_valid = 1'b0;
    n_checks++;
    if (dut_vec() !== {16'hAD92, 1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL auto_frame_done: got %h expected %h", dut_vec(), {16'hAD92, 1'b1, 1'b0, 4'd0});
    end
  endtask

  task automatic test_round_trip();
    logic       mux_out;
    logic [0:0] exp_bit;
    for (int s = 0; s < 16; s++) begin
      mux_out = ifc.out[15 - s];
      exp_bit = bit_q.pop_front();
      n_checks++;
      if (mux_out !== exp_bit[0]) begin
        n_fail++;
        $display("FAIL round_trip sel=%0d: got %b expected %b", s, mux_out, exp_bit[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    ifc.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      ifc.in_bit = 1'($urandom);
      tick();
      n_checks++;
      if (dut_vec() !== {16'hAD92, 1'b1, 1'b0, 4'd0}) begin
        n_fail++;
        $display("FAIL backpressure_c%0d: got %h expected %h", c, dut_vec(), {16'hAD92, 1'b1, 1'b0, 4'd0});
      end
    end
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b0;
    n_checks++;
    if (dut_vec() !== {16'h0000, 1'b0, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL release: got %h expected %h", dut_vec(), {16'h0000, 1'b0, 1'b1, 4'd0});
    end
  endtask

  task automatic test_addressed();
    logic [3:0] sels[3] = '{4'd0, 4'd15, 4'd7};
    int         n_wr;
    ifc.addr_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifc.sel      = sels[i];
      ifc.in_bit   = 1'b1;
      ifc.in_last  = (i == 2);
      ifc.in_valid = 1'b1;
      tick();
      n_checks++;
      if (dut_vec() !== model_vec() || ifc.bit_index !== 4'd0) begin
        n_fail++;
        $display("FAIL addr_write%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    n_checks++;
    if (dut_vec() !== {16'h8101, 1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL addr_frame: got %h expected %h", dut_vec(), {16'h8101, 1'b1, 1'b0, 4'd0});
    end
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;

    // Random addressed frame with idle gaps and possible rewrites of a sel.
    n_wr = $urandom_range(3, 10);
    for (int i = 0; i < n_wr; i++) begin
      ifc.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      ifc.sel      = 4'($urandom_range(0, 15));
      ifc.in_bit   = 1'($urandom);
      ifc.in_last  = (i == n_wr - 1);
      ifc.in_valid = 1'b1;
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL addr_rand%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    ifc.addr_mode = 1'b0;
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL addr_release: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_random_auto();
    logic [15:0] word;
    logic [15:0] expv;
    int          s;
    int          budget;
    bit          acc;
    for (int f = 0; f < 3; f++) begin
      word = 16'($urandom);
      exp_q.push_back(word);
      s = 0;
      budget = 200;
      while (s < 16 && budget > 0) begin
        ifc.in_valid = 1'($urandom_range(0, 1));
        ifc.in_bit   = word[15 - s];
        acc = ifc.in_valid && ifc.in_ready;
        tick();
        budget--;
        if (acc) s++;
        n_checks++;
        if (dut_vec() !== model_vec()) begin
          n_fail++;
          $display("FAIL rand_auto f%0d s%0d: got %h expected %h", f, s, dut_vec(), model_vec());
        end
      end
      ifc.in_valid = 1'b0;
      if (budget == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_auto_timeout f%0d: got %0d bits expected 16", f, s);
      end
      repeat ($urandom_range(0, 4)) tick();
      expv = exp_q.pop_front();
      n_checks++;
      if (ifc.out !== expv || ifc.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_auto_frame%0d: got %h/%b expected %h/1", f, ifc.out, ifc.out_valid, expv);
      end
      ifc.out_ready = 1'b1;
      tick();
      ifc.out_ready = 1'b0;
    end
  endtask

  task automatic test_abort();
    logic [15:0] word;
    ifc.addr_mode = 1'b0;
    ifc.in_valid  = 1'b1;
    for (int s = 0; s < 9; s++) begin
      ifc.in_bit = 1'($urandom);
      tick();
    end
    ifc.abort  = 1'b1;
    ifc.in_bit = 1'b1;
    tick();
    ifc.abort    = 1'b0;
    ifc.in_valid = 1'b0;
    n_checks++;
    if (dut_vec() !== {16'h0000, 1'b0, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL abort: got %h expected %h", dut_vec(), {16'h0000, 1'b0, 1'b1, 4'd0});
    end
    word = 16'($urandom);
    ifc.in_valid = 1'b1;
    for (int s = 0; s < 16; s++) begin
      ifc.in_bit = word[15 - s];
      tick();
    end
    ifc.in_valid = 1'b0;
    n_checks++;
    if (dut_vec() !== {word, 1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL after_abort_frame: got %h expected %h", dut_vec(), {word, 1'b1, 1'b0, 4'd0});
    end
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    ifc.in_valid = 1'b1;
    for (int s = 0; s < 16; s++) begin
      ifc.in_bit = 1'b1;
      tick();
    end
    ifc.in_valid = 1'b0;
    n_checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL pre_reset_hold: got %h/%b expected ffff/1", ifc.out, ifc.out_valid);
    end
    rst = 1'b1;
    ifc.out_ready = 1'b1;
    tick();
    rst = 1'b0;
    ifc.out_ready = 1'b0;
    n_checks++;
    if (dut_vec() !== {16'h0000, 1'b0, 1'b1, 4'd0} || ifc.state !== COLLECT) begin
      n_fail++;
      $display("FAIL mid_reset: got %h expected %h", dut_vec(), {16'h0000, 1'b0, 1'b1, 4'd0});
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst           = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_bit    = 1'b0;
    ifc.addr_mode = 1'b0;
    ifc.sel       = 4'd0;
    ifc.in_last   = 1'b0;
    ifc.abort     = 1'b0;
    ifc.out_ready = 1'b0;
    model_clear();

    test_reset();
    test_auto_frame();
    test_round_trip();
    test_backpressure();
    test_addressed();
    test_random_auto();
    test_abort();
    test_mid_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
